// File: rtl/mdu_iterative_if.sv
// rtl/mdu_iterative_if.sv - request/response bundle between EX issue logic and the iterative MDU
interface mdu_iterative_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
);
  logic                  md_op_valid_i;
  logic [OP_WIDTH-1:0]   mdu_op_i;
  logic [DATA_WIDTH-1:0] operand_a_i;
  logic [DATA_WIDTH-1:0] operand_b_i;
  logic                  kill_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  result_valid_o;

  modport master (
    output md_op_valid_i, mdu_op_i, operand_a_i, operand_b_i, kill_i,
    input  ready_o, result_o, result_valid_o
  );

  modport slave (
    input  md_op_valid_i, mdu_op_i, operand_a_i, operand_b_i, kill_i,
    output ready_o, result_o, result_valid_o
  );
endinterface

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative RV32M multiply/divide unit, fixed 34-cycle latency
module mdu_iterative #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  mdu_iterative_if.slave  bus
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_MULHU  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_DIVU   = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_REM    = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_REMU   = OP_WIDTH'(7);

  localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [OP_WIDTH-1:0]  op;
  logic                 sign_a, sign_b;
  logic [W-1:0]         mag_a, mag_b, a_raw;
  logic                 b_zero, ovf;
  logic [2*W-1:0]       acc;
  logic [W-1:0]         result;

  logic                 accept;
  logic                 in_a_signed, in_b_signed, in_sign_a, in_sign_b;
  logic [W-1:0]         in_mag_a, in_mag_b;

  logic [W:0]           mul_sum;
  logic [2*W-1:0]       mul_next;
  logic [W:0]           rem_sh;
  logic                 div_ge;
  logic [W-1:0]         div_rem;
  logic [2*W-1:0]       div_next;

  logic [2*W-1:0]       prod;
  logic [W-1:0]         quo_mag, rem_mag;
  logic [W-1:0]         fix_result;

  assign accept = (state == S_IDLE) && bus.md_op_valid_i && !bus.kill_i;

  // Operand a is unsigned only for MULHU/DIVU/REMU; b is also unsigned for MULHSU.
  assign in_a_signed = !(bus.mdu_op_i == OP_MULHU || bus.mdu_op_i == OP_DIVU ||
                         bus.mdu_op_i == OP_REMU);
  assign in_b_signed = in_a_signed && (bus.mdu_op_i != OP_MULHSU);
  assign in_sign_a   = in_a_signed && bus.operand_a_i[W-1];
  assign in_sign_b   = in_b_signed && bus.operand_b_i[W-1];
  assign in_mag_a    = in_sign_a ? -bus.operand_a_i : bus.operand_a_i;
  assign in_mag_b    = in_sign_b ? -bus.operand_b_i : bus.operand_b_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = S_CALC;
      S_CALC: begin
        if (bus.kill_i)            state_next = S_IDLE;
        else if (cnt == CNT_LAST)  state_next = S_FIX;
      end
      S_FIX:  state_next = bus.kill_i ? S_IDLE : S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Multiply: acc = {partial_hi, multiplier}; add a when the low multiplier bit is set, then shift right.
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_a} : {(W+1){1'b0}});
  assign mul_next = {mul_sum, acc[W-1:1]};

  // Divide: acc = {remainder, dividend->quotient}; the shifted remainder needs W+1 bits when b > 2^(W-1).
  assign rem_sh   = acc[2*W-1:W-1];
  assign div_ge   = rem_sh >= {1'b0, mag_b};
  assign div_rem  = W'(rem_sh - {1'b0, mag_b});
  assign div_next = div_ge ? {div_rem, acc[W-2:0], 1'b1}
                           : {rem_sh[W-1:0], acc[W-2:0], 1'b0};

  assign prod    = (sign_a ^ sign_b) ? -acc : acc;
  assign quo_mag = acc[W-1:0];
  assign rem_mag = acc[2*W-1:W];

  always_comb begin
    fix_result = '0;
    case (op)
      OP_MUL:                       fix_result = prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[2*W-1:W];
      OP_DIV, OP_DIVU: begin
        if (b_zero)               fix_result = '1;
        else if (ovf)             fix_result = MIN_INT;
        else if (sign_a ^ sign_b) fix_result = -quo_mag;
        else                      fix_result = quo_mag;
      end
      OP_REM, OP_REMU: begin
        if (b_zero)      fix_result = a_raw;
        else if (ovf)    fix_result = '0;
        else if (sign_a) fix_result = -rem_mag;
        else             fix_result = rem_mag;
      end
      default: fix_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op     <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      a_raw  <= '0;
      b_zero <= 1'b0;
      ovf    <= 1'b0;
      acc    <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        op     <= bus.mdu_op_i;
        sign_a <= in_sign_a;
        sign_b <= in_sign_b;
        mag_a  <= in_mag_a;
        mag_b  <= in_mag_b;
        a_raw  <= bus.operand_a_i;
        b_zero <= (bus.operand_b_i == '0);
        ovf    <= in_b_signed && (bus.operand_a_i == MIN_INT) && (bus.operand_b_i == '1);
        acc    <= bus.mdu_op_i[OP_WIDTH-1] ? {{W{1'b0}}, in_mag_a} : {{W{1'b0}}, in_mag_b};
      end else if (state == S_CALC) begin
        cnt <= cnt + 1'b1;
        acc <= op[OP_WIDTH-1] ? div_next : mul_next;
      end
      if (state == S_FIX && !bus.kill_i)
        result <= fix_result;
    end
  end

  assign bus.ready_o        = (state == S_IDLE);
  assign bus.result_valid_o = (state == S_DONE);
  assign bus.result_o       = result;
endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Iterative RV32M multiply/divide unit; the execution-side consumer of the decode controller's MD control outputs (MD-op flag plus 3-bit MDU opcode).
- Accepts one operation at a time, computes it with a radix-2 shift-add (multiply) or restoring shift-subtract (divide) datapath, and returns one result word to the writeback mux.
- Sits in EX beside the ALU; the pipeline stalls on ready_o low.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported for RV32M.
- OP_WIDTH, 3, MDU opcode width.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- md_op_valid_i  input  1  request strobe (controller MD-op flag qualified by EX valid)
- mdu_op_i  input  OP_WIDTH  MDU_MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7
- operand_a_i  input  DATA_WIDTH  rs1 value
- operand_b_i  input  DATA_WIDTH  rs2 value
- kill_i  input  1  pipeline flush; aborts any in-flight operation
- ready_o  output  1  high in IDLE; the request is accepted on md_op_valid_i & ready_o
- result_o  output  DATA_WIDTH  result; held stable from result_valid_o until the next accept
- result_valid_o  output  1  one-cycle pulse when result_o is valid

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous and active-low. Reset forces state=IDLE, ready_o=1, result_valid_o=0, result_o=0, and clears all internal registers.
- States and transitions:
  - IDLE -> CALC on accept. The accept latches the opcode, operand signs and absolute values (per signedness rules), and clears the accumulator and counter.
  - CALC runs exactly DATA_WIDTH cycles. The 5-bit counter counts 0..31, and the state moves to FIX when the counter reaches 31.
  - FIX: one cycle. Applies sign correction and special cases, and registers result_o.
  - DONE: one cycle. result_valid_o=1, then the state returns to IDLE.
- Latency:
  - Fixed DATA_WIDTH+2 = 34 cycles from the accept edge to the result_valid_o cycle, for every opcode including special cases.
  - Back-to-back: ready_o is high in the cycle after DONE, so there is a minimum 35-cycle issue interval.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Signed operands are converted to magnitudes at accept.
- Multiply:
  - 64-bit product, each CALC cycle conditionally adding a<<i.
  - In FIX the product is negated if sign_a^sign_b (signed cases only).
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide:
  - Restoring algorithm on magnitudes, producing one quotient bit per cycle.
  - Quotient sign = sign_a^sign_b. Remainder sign = sign_a.
- Special cases (resolved in FIX, no early exit):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return operand_a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- ready_o and request handling:
  - ready_o=0 in CALC, FIX and DONE.
  - md_op_valid_i while ready_o=0 is ignored; the controller holds it.
- Simultaneous events:
  - Request and kill_i in the same IDLE cycle: kill wins and nothing is accepted.
- kill_i:
  - In CALC or FIX: next state is IDLE, no result_valid_o, result_o unchanged.
  - In DONE: the pulse still completes; the pipeline discards it.
- Reset mid-operation: immediate return to IDLE; no result_valid_o after reset release.
- Invariants:
  - result_o changes only on the FIX->DONE edge.
  - result_valid_o is never asserted for two consecutive cycles.

Test Plan:
- MUL: a=0x00000007, b=0xFFFFFFFD -> 0xFFFFFFEB; result_valid_o exactly 34 cycles after accept; ready_o low throughout.
- MULH/MULHSU/MULHU with a=0xFFFFFFFE, b=0x00000003 -> 0xFFFFFFFF, 0xFFFFFFFF, 0x00000002 respectively.
- DIV/REM overflow: a=0x80000000, b=0xFFFFFFFF -> DIV 0x80000000, REM 0x00000000. REM a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFF (-1).
- Divide by zero: DIVU a=7, b=0 -> 0xFFFFFFFF; REMU a=7, b=0 -> 0x00000007; latency still 34.
- kill_i at cycle 10 of CALC -> ready_o high next cycle, no result_valid_o, result_o keeps the prior value. A new DIVU 100/7 is then accepted -> 14.
- rst_n low at cycle 20 of a DIV -> outputs at reset values immediately (async). After release, no spurious result_valid_o, and the next MUL 3*5 -> 15.
